instr_prog_buffer: RTL and testbench

INSTR_PROG_BUFFER -- requirements
Module: instr_prog_buffer

---
 rtl/instr_pkg.sv | 29 ++
 rtl/instr_prog_mem.sv | 36 +++
 rtl/instr_prog_buffer.sv | 174 +++++++++++++++++
 tb/tb_instr_prog_buffer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// -----------------------------------------------------------------------------
// instr_pkg
// Shared definitions for the instruction program buffer:
//   - DEFAULT_DEPTH : default number of stored instruction bytes
//   - OP_*          : 2-bit opcode field values (instruction bits [7:6])
//   - state_t       : playback FSM state encoding
//   - make_instr    : packs an opcode and a 6-bit operand into one byte
// -----------------------------------------------------------------------------
package instr_pkg;

    localparam int DEFAULT_DEPTH = 8;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic [7:0] make_instr(input logic [1:0] op,
                                              input logic [5:0] operand);
        return {op, operand};
    endfunction

endpackage

// File: rtl/instr_prog_mem.sv
// -----------------------------------------------------------------------------
// instr_prog_mem
// DEPTH x 8 register file holding the stored program. One synchronous write
// port and one asynchronous read port; the owner registers the read data.
// Contents are not reset: entries beyond the stored count are never read out.
//
// Ports:
//   clk      : clock
//   i_we     : write enable
//   i_waddr  : write index
//   i_wdata  : byte to store
//   i_raddr  : read index
//   o_rdata  : byte at i_raddr (combinational)
// -----------------------------------------------------------------------------
module instr_prog_mem #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [7:0]               i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [7:0]               o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_prog_buffer.sv
// -----------------------------------------------------------------------------
// instr_prog_buffer
// Records a short program of instruction bytes while idle, then plays it back
// to a downstream ALU FSM with a valid/ready handshake. Playback does not
// consume the program, so it can be replayed by another start.
//
// Ports:
//   clk          : clock, all state changes on rising edge
//   rst          : synchronous active-high reset, overrides everything
//   ena          : global enable; low freezes all state and outputs
//   wr_en/wr_data: append a byte to the program (IDLE only)
//   clr          : discard program and clear overflow (IDLE only, top priority)
//   start        : begin playback (IDLE only)
//   instr_ready  : downstream accepts instr_out
//   instr_out    : current program entry, 0x00 when instr_valid is low
//   instr_valid  : instr_out holds a program entry
//   count        : number of stored entries
//   full / empty : count == DEPTH / count == 0
//   busy         : FSM not in IDLE
//   done         : one-cycle pulse at the end of playback
//   overflow     : sticky, a write was dropped because the buffer was full
// -----------------------------------------------------------------------------
module instr_prog_buffer
    import instr_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   clr,
    input  logic                   start,
    input  logic                   instr_ready,
    output logic [7:0]             instr_out,
    output logic                   instr_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_rd_ptr;
    logic            r_overflow;
    logic            r_done;
    logic            r_instr_valid;
    logic [7:0]      r_instr_out;

    logic            w_full;
    logic            w_empty;
    logic            w_idle_cmd;
    logic            w_wr_accept;
    logic            w_xfer;
    logic            w_last;
    logic [AW-1:0]   w_rd_addr;
    logic [7:0]      w_rd_data;
    logic [7:0]      w_first_data;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Commands are only honoured in IDLE, with the clock enabled and no reset.
    assign w_idle_cmd  = ena && !rst && (r_state == ST_IDLE);
    assign w_wr_accept = w_idle_cmd && !clr && wr_en && !w_full;

    assign w_xfer = r_instr_valid && instr_ready;
    assign w_last = ({1'b0, r_rd_ptr} == (r_count - CW'(1)));

    // During PLAY the memory is addressed one ahead so the next entry is
    // ready to be registered on a transfer; from IDLE, entry 0 is fetched.
    assign w_rd_addr = (r_state == ST_PLAY) ? (r_rd_ptr + AW'(1)) : '0;

    // When the program is empty and a write coincides with start, the byte
    // landing in entry 0 this cycle is not yet in the memory; forward it.
    assign w_first_data = w_empty ? wr_data : w_rd_data;

    instr_prog_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_accept),
        .i_waddr (r_count[AW-1:0]),
        .i_wdata (wr_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_overflow    <= 1'b0;
            r_done        <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr_out   <= 8'h00;
        end else if (ena) begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (clr) begin
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                    end else begin
                        if (wr_en) begin
                            if (!w_full) begin
                                r_count <= r_count + CW'(1);
                            end else begin
                                r_overflow <= 1'b1;
                            end
                        end
                        if (start) begin
                            // A same-cycle write makes the program non-empty.
                            if (!w_empty || wr_en) begin
                                r_state       <= ST_PLAY;
                                r_rd_ptr      <= '0;
                                r_instr_valid <= 1'b1;
                                r_instr_out   <= w_first_data;
                            end else begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end

                ST_PLAY: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_state       <= ST_DONE;
                            r_done        <= 1'b1;
                            r_instr_valid <= 1'b0;
                            r_instr_out   <= 8'h00;
                            r_rd_ptr      <= '0;
                        end else begin
                            r_rd_ptr    <= r_rd_ptr + AW'(1);
                            r_instr_out <= w_rd_data;
                        end
                    end
                end

                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state       <= ST_IDLE;
                    r_done        <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_instr_out   <= 8'h00;
                end
            endcase
        end
    end

    assign instr_out   = r_instr_out;
    assign instr_valid = r_instr_valid;
    assign count       = r_count;
    assign full        = w_full;
    assign empty       = w_empty;
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_instr_prog_buffer.sv
module tb_instr_prog_buffer;
    import instr_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst, ena, wr_en, clr, start, instr_ready;
    logic [7:0]    wr_data;
    logic [7:0]    instr_out;
    logic          instr_valid;
    logic [CW-1:0] count;
    logic          full, empty, busy, done, overflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instr_prog_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .clr         (clr),
        .start       (start),
        .instr_ready (instr_ready),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    typedef struct {
        logic       ena, wr_en, clr, start, ready;
        logic [7:0] wd;
        logic [7:0] e_out;
        logic       e_valid;
        int         e_count;
        logic       e_busy, e_done, e_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic en, input logic wr, input logic [7:0] wd,
                                input logic cl, input logic st, input logic rdy,
                                input logic [7:0] eo, input logic ev, input int ec,
                                input logic eb, input logic ed, input logic eov);
        vec_t v;
        v.ena = en; v.wr_en = wr; v.wd = wd; v.clr = cl; v.start = st; v.ready = rdy;
        v.e_out = eo; v.e_valid = ev; v.e_count = ec;
        v.e_busy = eb; v.e_done = ed; v.e_ovf = eov;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] e_out, input logic e_valid,
                              input int e_count, input logic e_busy, input logic e_done,
                              input logic e_ovf);
        chk({tag, ".instr_out"},   32'(instr_out),   32'(e_out));
        chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(e_valid));
        chk({tag, ".count"},       32'(count),       32'(e_count));
        chk({tag, ".full"},        32'(full),        32'(e_count == DEPTH));
        chk({tag, ".empty"},       32'(empty),       32'(e_count == 0));
        chk({tag, ".busy"},        32'(busy),        32'(e_busy));
        chk({tag, ".done"},        32'(done),        32'(e_done));
        chk({tag, ".overflow"},    32'(overflow),    32'(e_ovf));
        $display("%s: out=%02h valid=%0b count=%0d busy=%0b done=%0b ovf=%0b",
                 tag, instr_out, instr_valid, count, busy, done, overflow);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        step();
        wr_en   = 1'b0;
        wr_data = 8'h00;
    endtask

    logic [7:0] prog5 [5];
    logic [7:0] prog3 [3];

    initial begin
        // LOAD 1, LOAD 2, ADD 1, ADD 2, STORE 0 -> 41 42 81 82 C0
        prog5[0] = make_instr(OP_LOAD, 6'd1);
        prog5[1] = make_instr(OP_LOAD, 6'd2);
        prog5[2] = make_instr(OP_ADD, 6'd1);
        prog5[3] = make_instr(OP_ADD, 6'd2);
        prog5[4] = make_instr(OP_STORE, 6'd0);
        prog3[0] = 8'h44;
        prog3[1] = 8'h83;
        prog3[2] = 8'hC0;

        //   en wr data clr st rdy | out  v cnt busy done ovf
        add(1, 1, 8'h41, 0, 0, 0,  8'h00, 0, 1, 0, 0, 0);
        add(1, 1, 8'h42, 0, 0, 0,  8'h00, 0, 2, 0, 0, 0);
        add(1, 1, 8'h81, 0, 0, 0,  8'h00, 0, 3, 0, 0, 0);
        add(1, 1, 8'h82, 0, 0, 0,  8'h00, 0, 4, 0, 0, 0);
        add(1, 1, 8'hC0, 0, 0, 0,  8'h00, 0, 5, 0, 0, 0);
        add(0, 1, 8'h77, 0, 1, 0,  8'h00, 0, 5, 0, 0, 0);  // ena low: ignored
        add(1, 0, 8'h00, 0, 1, 1,  8'h41, 1, 5, 1, 0, 0);  // start at N
        add(1, 0, 8'h00, 0, 0, 1,  8'h42, 1, 5, 1, 0, 0);
        add(1, 0, 8'h00, 0, 0, 1,  8'h81, 1, 5, 1, 0, 0);
        add(1, 0, 8'h00, 0, 0, 1,  8'h82, 1, 5, 1, 0, 0);
        add(1, 0, 8'h00, 0, 0, 1,  8'hC0, 1, 5, 1, 0, 0);
        add(1, 0, 8'h00, 0, 0, 1,  8'h00, 0, 5, 1, 1, 0);  // done at N+6
        add(1, 0, 8'h00, 0, 0, 0,  8'h00, 0, 5, 0, 0, 0);
        add(1, 0, 8'h00, 1, 0, 0,  8'h00, 0, 0, 0, 0, 0);  // clr
        add(1, 0, 8'h00, 0, 1, 0,  8'h00, 0, 0, 1, 1, 0);  // start while empty
        add(1, 0, 8'h00, 0, 0, 0,  8'h00, 0, 0, 0, 0, 0);
        add(1, 1, 8'h3F, 0, 1, 0,  8'h3F, 1, 1, 1, 0, 0);  // write+start together
        add(1, 0, 8'h00, 0, 0, 1,  8'h00, 0, 1, 1, 1, 0);
        add(1, 0, 8'h00, 0, 0, 0,  8'h00, 0, 1, 0, 0, 0);
        add(1, 1, 8'h55, 0, 0, 0,  8'h00, 0, 2, 0, 0, 0);
        add(1, 1, 8'h66, 1, 1, 0,  8'h00, 0, 0, 0, 0, 0);  // clr wins

        rst = 1'b1; ena = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
        clr = 1'b0; start = 1'b0; instr_ready = 1'b0;
        step();
        step();
        check_outs("reset", 8'h00, 0, 0, 0, 0, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            ena = vecs[i].ena; wr_en = vecs[i].wr_en; wr_data = vecs[i].wd;
            clr = vecs[i].clr; start = vecs[i].start; instr_ready = vecs[i].ready;
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_valid,
                       vecs[i].e_count, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_ovf);
        end
        ena = 1'b1; wr_en = 1'b0; clr = 1'b0; start = 1'b0; instr_ready = 1'b0;

        // Stall: ready low on N+1..N+3, junk commands during PLAY are ignored
        for (int i = 0; i < 5; i++) write_byte(prog5[i]);
        start = 1'b1;
        step();
        start = 1'b0;
        check_outs("stall.N+1", prog5[0], 1, 5, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            wr_en = 1'b1; wr_data = 8'hEE; clr = 1'b1; start = 1'b1;
            step();
            check_outs($sformatf("stall.hold%0d", k), prog5[0], 1, 5, 1, 0, 0);
        end
        wr_en = 1'b0; clr = 1'b0; start = 1'b0; instr_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            step();
            check_outs($sformatf("stall.resume%0d", i), prog5[i], 1, 5, 1, 0, 0);
        end
        step();
        check_outs("stall.done", 8'h00, 0, 5, 1, 1, 0);
        instr_ready = 1'b0;
        step();
        check_outs("stall.idle", 8'h00, 0, 5, 0, 0, 0);

        // Overflow: nine writes, only eight kept
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int v = 1; v <= 9; v++) begin
            write_byte(8'(v));
            check_outs($sformatf("ovf.wr%0d", v), 8'h00, 0, (v > 8) ? 8 : v, 0, 0, v == 9);
        end
        start = 1'b1; instr_ready = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_outs($sformatf("ovf.play%0d", i), 8'(i + 1), 1, 8, 1, 0, 1);
            step();
        end
        check_outs("ovf.done", 8'h00, 0, 8, 1, 1, 1);
        instr_ready = 1'b0;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_outs("ovf.clr", 8'h00, 0, 0, 0, 0, 0);

        // Reset on the 3rd playback cycle (ena low too: reset still wins)
        for (int i = 0; i < 5; i++) write_byte(prog5[i]);
        start = 1'b1; instr_ready = 1'b1;
        step();
        start = 1'b0;
        check_outs("rst.play1", prog5[0], 1, 5, 1, 0, 0);
        step();
        check_outs("rst.play2", prog5[1], 1, 5, 1, 0, 0);
        step();
        check_outs("rst.play3", prog5[2], 1, 5, 1, 0, 0);
        rst = 1'b1; ena = 1'b0;
        step();
        rst = 1'b0; ena = 1'b1;
        check_outs("rst.after", 8'h00, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_outs($sformatf("rst.quiet%0d", k), 8'h00, 0, 0, 0, 0, 0);
        end

        // Replay twice; second run has ena low for 2 cycles mid-play
        for (int i = 0; i < 3; i++) write_byte(prog3[i]);
        for (int run = 0; run < 2; run++) begin
            start = 1'b1; instr_ready = 1'b1;
            step();
            start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                check_outs($sformatf("replay%0d.out%0d", run, i), prog3[i], 1, 3, 1, 0, 0);
                if (run == 1 && i == 1) begin
                    for (int k = 0; k < 2; k++) begin
                        ena = 1'b0; wr_en = 1'b1; wr_data = 8'h99;
                        step();
                        check_outs($sformatf("replay1.frozen%0d", k), prog3[1], 1, 3, 1, 0, 0);
                    end
                    ena = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
                end
                step();
            end
            check_outs($sformatf("replay%0d.done", run), 8'h00, 0, 3, 1, 1, 0);
            instr_ready = 1'b0;
            step();
            check_outs($sformatf("replay%0d.idle", run), 8'h00, 0, 3, 0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
